// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback and drives all datapath controls.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       illegal_op,
    output logic       instr_done
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    state_t state_q, state_d;
    logic   pc_write;
    logic   branch;

    // State register; reset lands in FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; strobes are gated off while in reset.
    always_comb begin
        state_d    = FETCH;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        illegal_op = 1'b0;
        instr_done = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                state_d = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
                state_d    = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            default: state_d = FETCH;
        endcase
        pc_en = pc_write | (branch & zero);
        if (reset) begin
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            pc_en      = 1'b0;
            illegal_op = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl.
// Per-cycle expected control vectors are queued on drive and checked on the falling edge.
module tb_multicycle_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    localparam int S_FE = 0, S_DE = 1, S_MA = 2, S_MR = 3, S_MW = 4;
    localparam int S_WR = 5, S_EX = 6, S_AW = 7, S_BR = 8, S_AE = 9;
    localparam int S_AB = 10, S_JP = 11, S_ILL = 16;

    localparam logic [16:0] ALL    = 17'h1ffff;
    localparam logic [16:0] STROBE = 17'b11010010000000111;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_write, iord, ir_write, reg_dst;
    logic       mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       pc_en, illegal_op, instr_done;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       rdy;
        logic       z;
        int         st;
    } step_t;

    typedef struct {
        logic [16:0] val;
        logic [16:0] mask;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    wire [16:0] got = {mem_req, mem_write, iord, ir_write, reg_dst,
                       mem_to_reg, reg_write, alu_src_a, alu_src_b,
                       alu_op, pc_src, pc_en, illegal_op, instr_done};

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .iord       (iord),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .pc_en      (pc_en),
        .illegal_op (illegal_op),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    // Control vector a given state must show, written from the state table.
    function automatic logic [16:0] expv(int st, logic rdy, logic z);
        logic [16:0] v;
        v = '0;
        case (st)
            S_FE:  begin v[16] = 1; v[8:7] = 2'b01; v[13] = rdy; v[2] = rdy; end
            S_DE:  v[8:7] = 2'b11;
            S_ILL: begin v[8:7] = 2'b11; v[1] = 1; v[0] = 1; end
            S_MA,
            S_AE:  begin v[9] = 1; v[8:7] = 2'b10; end
            S_MR:  begin v[16] = 1; v[14] = 1; end
            S_MW:  begin v[10] = 1; v[11] = 1; v[0] = 1; end
            S_WR:  begin v[16] = 1; v[15] = 1; v[14] = 1; v[0] = rdy; end
            S_EX:  begin v[9] = 1; v[6:5] = 2'b10; end
            S_AW:  begin v[10] = 1; v[12] = 1; v[0] = 1; end
            S_BR:  begin
                v[9] = 1; v[6:5] = 2'b01; v[4:3] = 2'b01; v[2] = z; v[0] = 1;
            end
            S_AB:  begin v[10] = 1; v[0] = 1; end
            S_JP:  begin v[4:3] = 2'b10; v[2] = 1; v[0] = 1; end
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic step_t mk(logic rst, logic [5:0] o, logic rdy,
                                 logic z, int st);
        step_t s;
        s.rst = rst; s.op = o; s.rdy = rdy; s.z = z; s.st = st;
        return s;
    endfunction

    // Drive one cycle of stimulus and queue what the DUT must show for it.
    task automatic apply(input step_t s);
        exp_t e;
        reset     = s.rst;
        op        = s.op;
        mem_ready = s.rdy;
        zero      = s.z;
        e.val  = s.rst ? 17'h0 : expv(s.st, s.rdy, s.z);
        e.mask = s.rst ? STROBE : ALL;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        step_t p[$];
        exp_t  e;
        p.push_back(mk(1, OP_R, 1, 1, S_FE));
        p.push_back(mk(1, OP_J, 1, 1, S_FE));
        foreach (p[i]) begin
            apply(p[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ((got & e.mask) !== (e.val & e.mask))
                $display("FAIL reset[%0d] got=%b exp=%b", i, got, e.val);
            else
                passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        step_t p[$];
        exp_t  e;
        p.push_back(mk(0, OP_R, 1, 0, S_FE));
        p.push_back(mk(0, OP_R, 1, 0, S_DE));
        p.push_back(mk(0, OP_R, 1, 0, S_EX));
        p.push_back(mk(0, OP_R, 1, 0, S_AW));
        foreach (p[i]) begin
            apply(p[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ((got & e.mask) !== (e.val & e.mask))
                $display("FAIL rtype[%0d] got=%b exp=%b", i, got, e.val);
            else
                passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_wait();
        step_t p[$];
        exp_t  e;
        p.push_back(mk(0, OP_LW, 0, 0, S_FE));
        p.push_back(mk(0, OP_LW, 0, 0, S_FE));
        p.push_back(mk(0, OP_LW, 1, 0, S_FE));
        p.push_back(mk(0, OP_LW, 1, 0, S_DE));
        p.push_back(mk(0, OP_LW, 1, 0, S_MA));
        p.push_back(mk(0, OP_LW, 0, 0, S_MR));
        p.push_back(mk(0, OP_LW, 0, 0, S_MR));
        p.push_back(mk(0, OP_LW, 0, 0, S_MR));
        p.push_back(mk(0, OP_LW, 1, 0, S_MR));
        p.push_back(mk(0, OP_LW, 1, 0, S_MW));
        foreach (p[i]) begin
            apply(p[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ((got & e.mask) !== (e.val & e.mask))
                $display("FAIL lw[%0d] got=%b exp=%b", i, got, e.val);
            else
                passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_beq();
        step_t p[$];
        exp_t  e;
        p.push_back(mk(0, OP_BEQ, 1, 0, S_FE));
        p.push_back(mk(0, OP_BEQ, 1, 0, S_DE));
        p.push_back(mk(0, OP_BEQ, 1, 1, S_BR));
        p.push_back(mk(0, OP_BEQ, 1, 1, S_FE));
        p.push_back(mk(0, OP_BEQ, 1, 1, S_DE));
        p.push_back(mk(0, OP_BEQ, 1, 0, S_BR));
        foreach (p[i]) begin
            apply(p[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ((got & e.mask) !== (e.val & e.mask))
                $display("FAIL beq[%0d] got=%b exp=%b", i, got, e.val);
            else
                passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_wait();
        step_t p[$];
        exp_t  e;
        p.push_back(mk(0, OP_SW, 1, 0, S_FE));
        p.push_back(mk(0, OP_SW, 1, 0, S_DE));
        p.push_back(mk(0, OP_SW, 1, 0, S_MA));
        for (int k = 0; k < 4; k++)
            p.push_back(mk(0, OP_SW, 0, 0, S_WR));
        p.push_back(mk(0, OP_SW, 1, 0, S_WR));
        foreach (p[i]) begin
            apply(p[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ((got & e.mask) !== (e.val & e.mask))
                $display("FAIL sw[%0d] got=%b exp=%b", i, got, e.val);
            else
                passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal_then_j();
        step_t p[$];
        exp_t  e;
        p.push_back(mk(0, OP_BAD, 1, 0, S_FE));
        p.push_back(mk(0, OP_BAD, 1, 0, S_ILL));
        p.push_back(mk(0, OP_J, 1, 0, S_FE));
        p.push_back(mk(0, OP_J, 1, 0, S_DE));
        p.push_back(mk(0, OP_J, 1, 0, S_JP));
        foreach (p[i]) begin
            apply(p[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ((got & e.mask) !== (e.val & e.mask))
                $display("FAIL illegal_j[%0d] got=%b exp=%b", i, got, e.val);
            else
                passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_in_memwr();
        step_t p[$];
        exp_t  e;
        p.push_back(mk(0, OP_SW, 1, 0, S_FE));
        p.push_back(mk(0, OP_SW, 1, 0, S_DE));
        p.push_back(mk(0, OP_SW, 1, 0, S_MA));
        p.push_back(mk(0, OP_SW, 0, 0, S_WR));
        p.push_back(mk(1, OP_SW, 0, 0, S_WR));
        p.push_back(mk(0, OP_ADDI, 1, 0, S_FE));
        p.push_back(mk(0, OP_ADDI, 1, 0, S_DE));
        p.push_back(mk(0, OP_ADDI, 1, 0, S_AE));
        p.push_back(mk(0, OP_ADDI, 1, 0, S_AB));
        p.push_back(mk(0, OP_ADDI, 0, 0, S_FE));
        foreach (p[i]) begin
            apply(p[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ((got & e.mask) !== (e.val & e.mask))
                $display("FAIL rst_memwr[%0d] got=%b exp=%b", i, got, e.val);
            else
                passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_drain();
        checks++;
        if (sb.size() !== 0)
            $display("FAIL drain got=%0d exp=0", sb.size());
        else
            passed++;
    endtask

    initial begin
        reset     = 1'b1;
        op        = OP_R;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_sw_wait();
        test_illegal_then_j();
        test_reset_in_memwr();
        test_drain();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
